// File: rtl/term_pkg.sv
// Shared character constants and FSM state encodings for the terminal line port.
package term_pkg;

  localparam logic [7:0] EOF_CHAR = 8'hFF;
  localparam logic [7:0] CR_CHAR  = 8'h0D;
  localparam logic [7:0] LF_CHAR  = 8'h0A;
  localparam logic [7:0] BS_CHAR  = 8'h08;

  localparam logic [1:0] T_IDLE = 2'd0;
  localparam logic [1:0] T_SEND = 2'd1;
  localparam logic [1:0] T_CR   = 2'd2;
  localparam logic [1:0] T_LF   = 2'd3;

  localparam logic [0:0] R_COLLECT = 1'b0;
  localparam logic [0:0] R_HOLD    = 1'b1;

endpackage

// File: rtl/line_ram.sv
// DEPTH x 8 line buffer: one write port, one registered read port.
// A read of the address being written in the same cycle returns the new byte.
module line_ram #(
  parameter int DEPTH = 128,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [7:0]    wd,
  input  logic [AW-1:0] ra,
  output logic [7:0]    rd
);

  logic [7:0] mem [DEPTH];

  // NOTE: storage has no reset so it maps onto RAM primitives; contents survive rst.
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    rd <= (we && (wa == ra)) ? wd : mem[ra];
  end

endmodule

// File: rtl/term_line_port.sv
// Terminal line port: buffers an outgoing message and streams it with CR/LF,
// and collects an incoming line (with backspace editing) for readback.
module term_line_port
  import term_pkg::*;
#(
  parameter int         DEPTH = 128,
  parameter logic [7:0] EOF   = EOF_CHAR
) (
  input  logic       clk,
  input  logic       rst,
  output logic       dev_ready,
  input  logic       w_valid,
  output logic       w_ready,
  input  logic [7:0] w_addr,
  input  logic [7:0] w_data,
  input  logic       w_last,
  input  logic       r_valid,
  input  logic [7:0] r_addr,
  output logic       r_ready,
  output logic [7:0] r_data,
  output logic       r_last,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  input  logic       tx_ready,
  input  logic       rx_valid,
  input  logic [7:0] rx_data
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL  = (AW+1)'(DEPTH);
  localparam logic [AW:0] LIMIT = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] ONE   = (AW+1)'(1);

  logic [1:0]    tx_state;
  logic [AW:0]   tx_idx, tx_idx_nx;
  logic [AW-1:0] tx_ra;
  logic [7:0]    tx_rd;
  logic          tx_stop, w_fire;

  logic [0:0]    rx_state;
  logic [AW:0]   rx_len, rx_len_nx;
  logic [7:0]    rx_rd;
  logic          rx_fire, rx_store, r_fire, r_past, rd_pend, rd_eof;

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) dev_ready <= 1'b0;
    else     dev_ready <= 1'b1;
  end

  assign w_ready   = dev_ready && (tx_state == T_IDLE);
  assign w_fire    = w_valid && w_ready;
  assign tx_idx_nx = tx_idx + ONE;
  assign tx_stop   = (tx_idx == FULL) || (tx_rd == EOF);

  // The read address runs one byte ahead on a handshake so tx_rd always shows tx_buf[tx_idx].
  always_comb begin
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    tx_ra    = tx_idx[AW-1:0];
    case (tx_state)
      T_IDLE: tx_ra = '0;
      T_SEND: if (!tx_stop) begin
        tx_valid = 1'b1;
        tx_data  = tx_rd;
        if (tx_ready) tx_ra = tx_idx_nx[AW-1:0];
      end
      T_CR: begin
        tx_valid = 1'b1;
        tx_data  = CR_CHAR;
      end
      T_LF: begin
        tx_valid = 1'b1;
        tx_data  = LF_CHAR;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= T_IDLE;
      tx_idx   <= '0;
    end else begin
      case (tx_state)
        T_IDLE: if (w_fire && w_last) begin
          tx_state <= T_SEND;
          tx_idx   <= '0;
        end
        T_SEND: if (tx_stop)       tx_state <= T_CR;
                else if (tx_ready) tx_idx   <= tx_idx_nx;
        T_CR:   if (tx_ready)      tx_state <= T_LF;
        T_LF:   if (tx_ready)      tx_state <= T_IDLE;
        default: tx_state <= T_IDLE;
      endcase
    end
  end

  line_ram #(.DEPTH(DEPTH)) tx_buf (
    .clk (clk),
    .we  (w_fire && w_addr[7]),
    .wa  (w_addr[AW-1:0]),
    .wd  (w_data),
    .ra  (tx_ra),
    .rd  (tx_rd)
  );

  assign rx_fire   = dev_ready && rx_valid && (rx_state == R_COLLECT);
  assign rx_store  = rx_fire && (rx_data != CR_CHAR) && (rx_data != BS_CHAR)
                     && (rx_data != LF_CHAR) && (rx_len < LIMIT);
  assign rx_len_nx = rx_len + ONE;
  assign r_ready   = dev_ready && (rx_state == R_HOLD);
  assign r_fire    = r_valid && r_ready;
  assign r_past    = r_addr >= 8'(rx_len);

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state <= R_COLLECT;
      rx_len   <= '0;
      rd_pend  <= 1'b0;
      rd_eof   <= 1'b0;
    end else begin
      rd_pend <= r_fire;
      rd_eof  <= r_fire && r_past;
      if (rx_state == R_COLLECT) begin
        if (rx_fire && (rx_data == CR_CHAR))      rx_state <= R_HOLD;
        else if (rx_fire && (rx_data == BS_CHAR)) begin
          if (rx_len != '0) rx_len <= rx_len - ONE;
        end else if (rx_store)                     rx_len <= rx_len_nx;
      end else if (r_fire && r_past) begin
        // The end-of-line read releases the line; its response goes out next cycle.
        rx_state <= R_COLLECT;
        rx_len   <= '0;
      end
    end
  end

  line_ram #(.DEPTH(DEPTH)) rx_buf (
    .clk (clk),
    .we  (rx_store),
    .wa  (rx_len[AW-1:0]),
    .wd  (rx_data),
    .ra  (r_addr[AW-1:0]),
    .rd  (rx_rd)
  );

  assign r_data = rd_pend ? (rd_eof ? EOF : rx_rd) : 8'h00;
  assign r_last = rd_eof;

endmodule

// File: tb/tb_term_line_port.sv
// Directed bench for term_line_port: TX line framing, RX line editing and readback, reset.
module tb_term_line_port;

  logic       clk, rst;
  logic       dev_ready;
  logic       w_valid, w_ready, w_last;
  logic [7:0] w_addr, w_data;
  logic       r_valid, r_ready, r_last;
  logic [7:0] r_addr, r_data;
  logic       tx_valid, tx_ready;
  logic [7:0] tx_data;
  logic       rx_valid;
  logic [7:0] rx_data;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] got[$];

  term_line_port dut (
    .clk(clk), .rst(rst), .dev_ready(dev_ready),
    .w_valid(w_valid), .w_ready(w_ready), .w_addr(w_addr), .w_data(w_data), .w_last(w_last),
    .r_valid(r_valid), .r_addr(r_addr), .r_ready(r_ready), .r_data(r_data), .r_last(r_last),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d, input logic l);
    w_valid = 1'b1; w_addr = a; w_data = d; w_last = l;
    check("w_ready_idle", w_ready, 1);
    tick();
    w_valid = 1'b0; w_last = 1'b0;
  endtask

  task automatic rx_byte(input logic [7:0] b);
    rx_valid = 1'b1; rx_data = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [7:0] a, input logic [7:0] exp_d, input logic exp_l);
    r_valid = 1'b1; r_addr = a;
    check({tag, "_ready"}, r_ready, 1);
    tick();
    r_valid = 1'b0;
    check({tag, "_data"}, r_data, exp_d);
    check({tag, "_last"}, r_last, exp_l);
  endtask

  task automatic collect(input int n);
    got.delete();
    for (int c = 0; c < 40 && got.size() < n; c++) begin
      if (tx_valid && tx_ready) got.push_back(tx_data);
      tick();
    end
    check("tx_count", got.size(), n);
  endtask

  initial begin
    logic [7:0] exp_stream [4];

    rst = 1'b1; w_valid = 1'b0; w_addr = '0; w_data = '0; w_last = 1'b0;
    r_valid = 1'b0; r_addr = '0; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
    tick(); tick();
    check("rst_dev_ready", dev_ready, 0);
    check("rst_w_ready", w_ready, 0);
    check("rst_r_ready", r_ready, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_r_data", r_data, 0);
    check("rst_r_last", r_last, 0);
    rst = 1'b0;
    tick();
    check("dev_ready_rise", dev_ready, 1);
    check("r_ready_collect", r_ready, 0);

    // "Hi" then EOF, free-running transmitter
    tx_ready = 1'b1;
    wr(8'h80, 8'h48, 1'b0);
    wr(8'h81, 8'h69, 1'b0);
    wr(8'h82, 8'hFF, 1'b1);
    collect(4);
    exp_stream = '{8'h48, 8'h69, 8'h0D, 8'h0A};
    for (int i = 0; i < 4 && i < got.size(); i++) check("hi_stream", got[i], exp_stream[i]);
    check("hi_w_ready_after", w_ready, 1);
    check("hi_tx_idle", tx_valid, 0);

    // RX "42" CR, read back
    rx_byte(8'h34); rx_byte(8'h32); rx_byte(8'h0D);
    rd("rd42_0", 8'd0, 8'h34, 1'b0);
    rd("rd42_1", 8'd1, 8'h32, 1'b0);
    rd("rd42_2", 8'd2, 8'hFF, 1'b1);
    check("rd42_r_ready_after", r_ready, 0);
    tick();
    check("idle_r_data", r_data, 0);
    check("idle_r_last", r_last, 0);

    // Backspace editing: "12" BS "7" CR
    rx_byte(8'h31); rx_byte(8'h32); rx_byte(8'h08); rx_byte(8'h37); rx_byte(8'h0D);
    rd("bs_0", 8'd0, 8'h31, 1'b0);
    rd("bs_1", 8'd1, 8'h37, 1'b0);
    rd("bs_2", 8'd2, 8'hFF, 1'b1);

    // Overflow: 200 bytes, only the first 127 are kept
    for (int i = 0; i < 200; i++) rx_byte(8'h20 + 8'(i % 64));
    rx_byte(8'h0D);
    rd("ovf_0", 8'd0, 8'h20, 1'b0);
    rd("ovf_126", 8'd126, 8'h5E, 1'b0);
    rd("ovf_127", 8'd127, 8'hFF, 1'b1);

    // Back-pressure mid-line, with a write offered during T_SEND
    tx_ready = 1'b0;
    wr(8'h80, 8'h41, 1'b0);
    wr(8'h81, 8'h42, 1'b0);
    wr(8'h82, 8'h43, 1'b0);
    wr(8'h83, 8'hFF, 1'b1);
    check("bp_first_valid", tx_valid, 1);
    check("bp_first_data", tx_data, 8'h41);
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    w_valid = 1'b1; w_addr = 8'h80; w_data = 8'h55;
    for (int i = 0; i < 5; i++) begin
      check("bp_stall_valid", tx_valid, 1);
      check("bp_stall_data", tx_data, 8'h42);
      check("bp_w_ready_busy", w_ready, 0);
      tick();
    end
    w_valid = 1'b0;
    tx_ready = 1'b1;
    collect(4);
    exp_stream = '{8'h42, 8'h43, 8'h0D, 8'h0A};
    for (int i = 0; i < 4 && i < got.size(); i++) check("bp_stream", got[i], exp_stream[i]);

    // Reset during T_SEND aborts the line
    wr(8'h83, 8'hFF, 1'b1);
    check("abort_sending", tx_valid, 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_tx_valid", tx_valid, 0);
    check("abort_dev_ready", dev_ready, 0);
    check("abort_w_ready", w_ready, 0);
    tick();
    check("abort_dev_ready_back", dev_ready, 1);
    check("abort_tx_idle", tx_valid, 0);

    // New message; a non-region write is discarded; final write shares a cycle with a read
    rx_byte(8'h37); rx_byte(8'h0D);
    wr(8'h80, 8'h4F, 1'b0);
    wr(8'h81, 8'h4B, 1'b0);
    wr(8'h01, 8'h5A, 1'b0);
    w_valid = 1'b1; w_addr = 8'h82; w_data = 8'hFF; w_last = 1'b1;
    r_valid = 1'b1; r_addr = 8'd0;
    check("dual_w_ready", w_ready, 1);
    check("dual_r_ready", r_ready, 1);
    tick();
    w_valid = 1'b0; w_last = 1'b0; r_valid = 1'b0;
    check("dual_r_data", r_data, 8'h37);
    check("dual_r_last", r_last, 0);
    collect(4);
    exp_stream = '{8'h4F, 8'h4B, 8'h0D, 8'h0A};
    for (int i = 0; i < 4 && i < got.size(); i++) check("ok_stream", got[i], exp_stream[i]);
    rd("dual_end", 8'd1, 8'hFF, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
